// File: rtl/truth_table_pkg.sv
// Shared types, sizes and the index-to-bit mapping for the truth-table sweeper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int N_INPUTS = 4;
  localparam int TT_WIDTH = 16;

  // Input index 0 lands in the MSB of the truth table (Cello hex-code ordering).
  function automatic logic [3:0] tt_bit(input logic [N_INPUTS-1:0] idx);
    return 4'(TT_WIDTH - 1) - idx;
  endfunction

endpackage

// File: rtl/sense_sync.sv
// Two-flop synchronizer for the netlist output, which is asynchronous to the sweep.
module sense_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sense,
  output logic sense_sync
);

  logic meta_r;
  logic sync_r;

  // Shift the raw sense value through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= sense;
      sync_r <= meta_r;
    end
  end

  assign sense_sync = sync_r;

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input combinational netlist through all 16 input vectors, holds
// each for SETTLE_CYCLES, captures the synchronized output into a truth table
// and compares it against EXPECTED.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] EXPECTED      = 16'h93AC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  input  logic        out_sense,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] measured,
  output logic [15:0] mismatch
);

  // DRIVE lasts SETTLE_CYCLES-1 cycles, SAMPLE one more.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 2);

  state_e                state_r;
  logic [N_INPUTS-1:0]   idx_r;
  logic [7:0]            cnt_r;
  logic [N_INPUTS-1:0]   stim_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;
  logic [TT_WIDTH-1:0]   measured_r;
  logic [TT_WIDTH-1:0]   mismatch_r;
  logic [TT_WIDTH-1:0]   capture_s;
  logic                  sense_s;
  logic                  running_s;

  sense_sync u_sense_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sense      (out_sense),
    .sense_sync (sense_s)
  );

  // Truth table as it will look once the current row's sample is written.
  always_comb begin
    capture_s = measured_r;
    capture_s[tt_bit(idx_r)] = sense_s;
    running_s = (state_r == ST_DRIVE) || (state_r == ST_SAMPLE);
  end

  // Sweep FSM with settle counter, vector index, stimulus and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      cnt_r      <= 8'd0;
      stim_r     <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      measured_r <= 16'h0000;
      mismatch_r <= 16'h0000;
    end else if (abort) begin
      // Abort beats start and beats a same-cycle sample.
      state_r    <= ST_IDLE;
      idx_r      <= 4'd0;
      cnt_r      <= 8'd0;
      stim_r     <= 4'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      mismatch_r <= 16'h0000;
      if (running_s) begin
        measured_r <= 16'h0000;
      end else begin
        measured_r <= measured_r;
      end
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r    <= ST_DRIVE;
            idx_r      <= 4'd0;
            cnt_r      <= 8'd0;
            stim_r     <= 4'd0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            measured_r <= 16'h0000;
            mismatch_r <= 16'h0000;
          end else begin
            state_r <= state_r;
          end
        end
        ST_DRIVE: begin
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_DRIVE;
          end
        end
        ST_SAMPLE: begin
          measured_r <= capture_s;
          if (idx_r == 4'd15) begin
            // Last row: inputs park at 0000 and the verdict is registered.
            state_r    <= ST_DONE;
            stim_r     <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            pass_r     <= (capture_s == EXPECTED);
            mismatch_r <= capture_s ^ EXPECTED;
          end else begin
            state_r <= ST_DRIVE;
            idx_r   <= idx_r + 4'd1;
            stim_r  <= idx_r + 4'd1;
            cnt_r   <= 8'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          stim_r  <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in1      = stim_r[3];
  assign in2      = stim_r[2];
  assign in3      = stim_r[1];
  assign in4      = stim_r[0];
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign measured = measured_r;
  assign mismatch = mismatch_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: one instance at the default settle time (S=16) and one at S=4,
// each driving a behavioural model of the 0x93AC netlist (or a faulty variant).
module tb_truth_table_sweeper;

  localparam logic [15:0] GOLD = 16'h93AC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: S=16
  logic rst_n_a, start_a, abort_a, sense_a;
  logic in1_a, in2_a, in3_a, in4_a, busy_a, done_a, pass_a;
  logic [15:0] measured_a, mismatch_a;
  logic [1:0] mode_a;

  // Instance B: S=4
  logic rst_n_b, start_b, abort_b, sense_b;
  logic in1_b, in2_b, in3_b, in4_b, busy_b, done_b, pass_b;
  logic [15:0] measured_b, mismatch_b;
  logic [1:0] mode_b;

  truth_table_sweeper dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .abort(abort_a),
    .in1(in1_a), .in2(in2_a), .in3(in3_a), .in4(in4_a),
    .out_sense(sense_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .measured(measured_a), .mismatch(mismatch_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
    .in1(in1_b), .in2(in2_b), .in3(in3_b), .in4(in4_b),
    .out_sense(sense_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .measured(measured_b), .mismatch(mismatch_b)
  );

  // Netlist model: 0 golden, 1 stuck-0, 2 inverted golden, 3 stuck-1.
  function automatic logic netlist(input logic [1:0] mode, input logic [3:0] vec);
    logic [15:0] tt;
    tt = GOLD;
    case (mode)
      2'd0:    return tt[4'd15 - vec];
      2'd1:    return 1'b0;
      2'd2:    return ~tt[4'd15 - vec];
      default: return 1'b1;
    endcase
  endfunction

  assign sense_a = netlist(mode_a, {in1_a, in2_a, in3_a, in4_a});
  assign sense_b = netlist(mode_b, {in1_b, in2_b, in3_b, in4_b});

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start so that it is sampled by the next edge (edge 0); returns #1 after it.
  task automatic start_a_pulse();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic start_b_pulse();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  // Count edges after edge 0 until done is seen, bounded.
  task automatic wait_done_a(output int e);
    e = 0;
    while (!done_a && e < 300) begin
      @(posedge clk); #1;
      e++;
    end
  endtask

  task automatic wait_done_b(output int e);
    e = 0;
    while (!done_b && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
  endtask

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] meas;
    logic        pass;
    logic [15:0] mism;
  } vec_t;

  vec_t vecs [4];

  // Global bound in case something never completes.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e;
    int n;
    int busy_cnt;
    int first_done;
    int stim_err;
    int idx5_err;
    logic [3:0] exp_stim;

    vecs[0] = '{mode: 2'd0, meas: 16'h93AC, pass: 1'b1, mism: 16'h0000};
    vecs[1] = '{mode: 2'd1, meas: 16'h0000, pass: 1'b0, mism: 16'h93AC};
    vecs[2] = '{mode: 2'd2, meas: 16'h6C53, pass: 1'b0, mism: 16'hFFFF};
    vecs[3] = '{mode: 2'd3, meas: 16'hFFFF, pass: 1'b0, mism: 16'h6C53};

    rst_n_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; mode_a = 2'd0;
    rst_n_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; mode_b = 2'd0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_ctrl_a", 32'({in1_a, in2_a, in3_a, in4_a, busy_a, done_a, pass_a}), 32'd0);
    check("rst_meas_a", 32'(measured_a), 32'd0);
    check("rst_mism_a", 32'(mismatch_a), 32'd0);
    check("rst_ctrl_b", 32'({in1_b, in2_b, in3_b, in4_b, busy_b, done_b, pass_b}), 32'd0);
    check("rst_meas_b", 32'(measured_b), 32'd0);
    check("rst_mism_b", 32'(mismatch_b), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    @(posedge clk); #1;

    // Table-driven full sweeps at S=16
    for (int i = 0; i < 4; i++) begin
      mode_a = vecs[i].mode;
      start_a_pulse();
      check($sformatf("row%0d_clr_meas", i), 32'(measured_a), 32'd0);
      check($sformatf("row%0d_clr_done", i), 32'(done_a), 32'd0);
      check($sformatf("row%0d_busy", i), 32'(busy_a), 32'd1);
      wait_done_a(e);
      check($sformatf("row%0d_done_edge", i), 32'(e), 32'd256);
      check($sformatf("row%0d_measured", i), 32'(measured_a), 32'(vecs[i].meas));
      check($sformatf("row%0d_pass", i), 32'(pass_a), 32'(vecs[i].pass));
      check($sformatf("row%0d_mismatch", i), 32'(mismatch_a), 32'(vecs[i].mism));
      check($sformatf("row%0d_idle_out", i), 32'({in1_a, in2_a, in3_a, in4_a, busy_a}), 32'd0);
    end

    // Abort while DONE clears done/pass/mismatch
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("abort_done_flags", 32'({done_a, pass_a}), 32'd0);
    check("abort_done_mism", 32'(mismatch_a), 32'd0);

    // start together with abort in IDLE: stays idle
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_abort_idle", 32'({busy_a, done_a, in1_a, in2_a, in3_a, in4_a}), 32'd0);

    // S=4 timing sweep with an ignored start at cycle 30
    mode_b = 2'd0;
    busy_cnt = 0; first_done = -1; stim_err = 0; idx5_err = 0;
    start_b_pulse();
    for (int k = 0; k <= 70; k++) begin
      if (busy_b) busy_cnt++;
      if (done_b && first_done < 0) first_done = k;
      exp_stim = (k < 64) ? 4'(k / 4) : 4'd0;
      if ({in1_b, in2_b, in3_b, in4_b} !== exp_stim) stim_err++;
      if (k >= 20 && k <= 23 && {in1_b, in2_b, in3_b, in4_b} !== 4'b0101) idx5_err++;
      start_b = (k == 29) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start_b = 1'b0;
    check("s4_busy_cycles", 32'(busy_cnt), 32'd64);
    check("s4_done_edge", 32'(first_done), 32'd64);
    check("s4_stim_seq_errs", 32'(stim_err), 32'd0);
    check("s4_idx5_errs", 32'(idx5_err), 32'd0);
    check("s4_measured", 32'(measured_b), 32'(GOLD));
    check("s4_pass", 32'(pass_b), 32'd1);

    // Asynchronous reset while idx=7
    start_b_pulse();
    n = 0;
    while ({in1_b, in2_b, in3_b, in4_b} !== 4'd7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_idx7", 32'({in1_b, in2_b, in3_b, in4_b}), 32'd7);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n_b = 1'b0;
    #1;
    check("async_rst_ctrl", 32'({in1_b, in2_b, in3_b, in4_b, busy_b, done_b, pass_b}), 32'd0);
    check("async_rst_meas", 32'(measured_b), 32'd0);
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'({busy_b, done_b}), 32'd0);
    start_b_pulse();
    wait_done_b(e);
    check("post_rst_done_edge", 32'(e), 32'd64);
    check("post_rst_measured", 32'(measured_b), 32'(GOLD));
    check("post_rst_pass", 32'(pass_b), 32'd1);

    // Abort in the SAMPLE cycle of idx=3 (edge 15 enters SAMPLE, edge 16 would sample)
    start_b_pulse();
    repeat (15) @(posedge clk);
    #1;
    check("pre_abort_stim", 32'({in1_b, in2_b, in3_b, in4_b}), 32'd3);
    check("pre_abort_partial", 32'(measured_b), 32'h8000);
    abort_b = 1'b1;
    @(posedge clk); #1;
    abort_b = 1'b0;
    check("abort_meas", 32'(measured_b), 32'd0);
    check("abort_flags", 32'({busy_b, done_b, pass_b}), 32'd0);
    check("abort_stim", 32'({in1_b, in2_b, in3_b, in4_b}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'({busy_b, in1_b, in2_b, in3_b, in4_b}), 32'd0);
    start_b_pulse();
    wait_done_b(e);
    check("abort_rerun_edge", 32'(e), 32'd64);
    check("abort_rerun_pass", 32'(pass_b), 32'd1);
    check("abort_rerun_mism", 32'(mismatch_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
